// File: rtl/mux_grant_ctrl.sv
// mux_grant_ctrl: round-robin packet arbiter sequencing an N-to-1 output mux
module mux_grant_ctrl #(
  parameter int SIZE = 8,
  parameter int SEL_W = $clog2(SIZE),
  parameter int MAX_BEATS = 16,
  parameter int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [SIZE-1:0]  req,
  input  logic [SIZE-1:0]  last,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic [SIZE-1:0]  grant,
  output logic             valid,
  output logic             xfer
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic busy, rel;
  // first requester at or after ptr; offsets scanned high-to-low so the nearest wins
  always_comb begin
    pick = ptr_q;
    for (int i = SIZE - 1; i >= 0; i--)
      if (req[ptr_q + SEL_W'(i)]) pick = ptr_q + SEL_W'(i);
  end
  // outputs and release decision; tail or beat limit on an accepted beat frees the port
  always_comb begin
    busy = state_q == BUSY;
    sel = sel_q;
    grant = busy ? SIZE'(1) << sel_q : '0;
    valid = busy & req[sel_q];
    xfer = valid & ready;
    rel = xfer & (last[sel_q] | (beats_q == CNT_W'(MAX_BEATS - 1)));
  end
  // next state: grant from IDLE, hold in BUSY until release, owner gets lowest priority next
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    beats_d = beats_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = BUSY;
        sel_d = pick;
        beats_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      ptr_d = sel_q + SEL_W'(1);
      beats_d = '0;
    end else if (xfer) begin
      beats_d = beats_q + CNT_W'(1);
    end
  end
  // state register; reset drops ownership at once without release side effects
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      beats_q <= beats_d;
    end
endmodule

// File: doc/mux_grant_ctrl.md
# mux_grant_ctrl

Round-robin packet arbiter that sequences the shared N-to-1 datapath mux of a router output port. It picks one of SIZE requesters, drives the encoded mux select and a one-hot grant, and holds ownership until the requester's tail beat is accepted downstream or a beat-count limit forces release. It sits beside the output mux: the select output feeds the mux select input directly, and the grant and valid outputs go to the input buffers and the downstream stage.

## Interface
- SIZE, 8: number of requesters; power of 2, minimum 2.
- SEL_W, CLogB2(SIZE-1): width of the encoded select.
- MAX_BEATS, 16: forced-release limit in accepted beats per grant; minimum 1.
- CNT_W, CLogB2(MAX_BEATS): width of the beat counter.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  SIZE  per-requester beat-valid.
- last  input  SIZE  per-requester tail marker; qualified by req of the same index.
- ready  input  1  downstream accepts the current beat.
- sel  output  SEL_W  encoded owner index, to the mux select.
- grant  output  SIZE  one-hot owner (bit sel) while BUSY; otherwise zero.
- valid  output  1  beat on the mux output is valid: BUSY and req[sel].
- xfer  output  1  beat accepted this cycle: valid and ready.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner is held in the sel register.
- Registers:
  - state
  - sel (owner)
  - ptr (SEL_W, round-robin base)
  - beats (CNT_W)
- IDLE:
  - If req is nonzero, choose the first index i with req[i]=1, scanning ptr, ptr+1, … modulo SIZE.
  - Next edge: sel <= i, beats <= 0, state <= BUSY.
  - If req is zero, remain in IDLE; sel holds its last value.
- BUSY:
  - The owner keeps the grant regardless of other requests.
  - If req[sel] drops mid-packet, the grant is held and valid=0. There is no release without the tail or the limit.
  - On xfer: beats <= beats+1.
  - Release condition: xfer and (last[sel] or beats==MAX_BEATS-1).
  - On release: state <= IDLE, ptr <= sel+1 modulo SIZE (wrap from SIZE-1 to 0), beats <= 0.
- Combinational outputs:
  - grant = (state==BUSY) ? onehot(sel) : 0.
  - valid = (state==BUSY) & req[sel].
  - xfer = valid & ready.
- last is ignored when req is low or when the index is not the owner.
- ready while valid=0 has no effect.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - state=IDLE, sel=0, ptr=0, beats=0.
  - Therefore grant=0, valid=0, xfer=0.
- Reset mid-packet aborts ownership immediately; no release side effects.
- Arbitration latency: a req seen in IDLE at edge k gives grant and valid at cycle k+1. This is one registered decision stage.
- Release bubble:
  - The cycle after a release edge is always IDLE (grant=0).
  - The next grant appears one cycle later.
  - Minimum spacing between grants is therefore 2 cycles. Single-beat packets see 50% peak throughput, by design.
- Fairness: after owner j releases, j has the lowest priority at the next arbitration. A continuously requesting port waits at most SIZE-1 packets.
- Simultaneous events:
  - A last and beats==MAX_BEATS-1 tail on the same beat produce one release, not two.
  - A new req arriving on the release cycle is arbitrated on the following IDLE cycle, using the updated ptr.
- sel is stable for the whole BUSY period, so the mux output changes only across IDLE.

## Test plan
- Reset, then req=8'b0000_0100 with last[2]=1 and ready=1 on the first granted cycle:
  - grant=8'b0000_0100 and sel=2 one cycle after req.
  - xfer=1 for exactly one cycle.
  - grant=0 on the next cycle; ptr becomes 3.
- req=8'hFF held, all packets single-beat, ready=1:
  - Grant order is 0,1,2,…,7,0.
  - Each grant is separated by one IDLE cycle.
  - ptr wraps from 7 to 0.
- Owner 5 with a 4-beat packet while req=8'hFF, and ready toggling 1,0,1,1,0,1:
  - sel stays 5 throughout.
  - xfer pulses exactly 4 times.
  - Release follows the 4th xfer, which carries last[5].
  - The next grant goes to 6.
- MAX_BEATS=16, owner 1 streams with last=0 and ready=1:
  - Forced release after the 16th xfer.
  - The following grant goes to 2 if req[2]=1.
- Owner 3 drops req[3] for 3 cycles mid-packet:
  - valid=0 and grant[3]=1 are held during those cycles.
  - No other port is granted.
  - Beats resume when req[3] returns.
- Assert reset_n=0 in BUSY with sel=6 and beats=7:
  - All outputs go to 0 immediately, asynchronously.
  - After deassertion, req=8'h41 grants index 0 first (ptr=0).
